pipe_hazard_ctl: RTL and testbench
==================================

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

Interface
REQ-001 Parameter REG_ADDRW, default 5, register-id width.
REQ-002 Parameter CNT_W, default 32, stall performance counter width.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_idu_valid  in  1  ID stage holds a valid instruction.
REQ-006 i_idu_rs1id / i_idu_rs2id  in  REG_ADDRW  ID source register ids.
REQ-007 i_idu_rs1en / i_idu_rs2en  in  1  ID source register actually read.
REQ-008 i_idu_rdid  in  REG_ADDRW  ID destination id; i_idu_lden in 1 ID instruction is a load.
REQ-009 i_idu_mcop  in  1  ID instruction is multi-cycle in EX (mul/div).
REQ-010 i_exu_mc_done  in  1  multi-cycle EX op result valid this cycle.
REQ-011 i_exu_redirect  in  1  EX resolved taken branch/jump; younger IF/ID instructions wrong.
REQ-012 i_lsu_wait  in  1  memory stage not ready; whole pipe freezes.
REQ-013 o_pc_stall, o_ifid_stall  out  1  hold PC and IF/ID register.
REQ-014 o_ifid_flush  out  1  load NOP into IF/ID.
REQ-015 o_idex_bubble  out  1  drives the ID/EX register bubble input (NOP into EX).
REQ-016 o_idex_hold  out  1  ID/EX register keeps its contents.
REQ-017 o_exmem_bubble  out  1  NOP into EX/MEM; o_exmem_stall out 1 hold EX/MEM.
REQ-018 o_state  out  1  0=RUN, 1=MCWAIT (debug).
REQ-019 o_ldstall_cnt, o_mcstall_cnt  out  CNT_W  load-use / multi-cycle stall cycle counts.

Function
REQ-020 Tracker registers ex_vld, ex_rd, ex_ld, ex_mc describe the instruction currently in EX; updated only when pipe advances (no freeze, no hold).
REQ-021 On advance: tracker loads {i_idu_valid, i_idu_rdid, i_idu_lden, i_idu_mcop} unless o_idex_bubble is 1, then ex_vld=0, ex_ld=0, ex_mc=0.
REQ-022 Load-use hit = i_idu_valid & ex_vld & ex_ld & ex_rd!=0 & ((rs1en & rs1id==ex_rd) | (rs2en & rs2id==ex_rd)); x0 never hazards.
REQ-023 Per-cycle priority, highest first: i_lsu_wait, i_exu_redirect, MCWAIT-not-done, load-use hit, normal.
REQ-024 i_lsu_wait=1: pc_stall=ifid_stall=idex_hold=exmem_stall=1, all flush/bubble outputs 0; state, tracker, counters unchanged.
REQ-025 Redirect (no lsu_wait): ifid_flush=1, idex_bubble=1, stalls/holds 0; state->RUN, tracker invalidated; overrides a simultaneous load-use hit or MCWAIT.
REQ-026 MCWAIT and i_exu_mc_done=0: pc_stall=ifid_stall=idex_hold=1, exmem_bubble=1; o_mcstall_cnt +1.
REQ-027 MCWAIT and i_exu_mc_done=1: cycle treated as RUN (load-use check applies); state->RUN unless a new mcop issues this cycle.
REQ-028 RUN load-use hit: pc_stall=ifid_stall=1, idex_bubble=1; exactly one bubble per hit (tracker invalid next cycle); o_ldstall_cnt +1.
REQ-029 RUN->MCWAIT when an instruction with i_idu_mcop=1 advances into EX without bubble; earliest done is the following cycle.
REQ-030 Normal cycle: all outputs 0.
REQ-031 Outputs are combinational from state, tracker and inputs (zero latency); only state, tracker, counters are registered.
REQ-032 Counters wrap modulo 2^CNT_W; not incremented during lsu_wait or redirect cycles.

Reset
REQ-033 i_rst=1 at edge: state=RUN, ex_vld=ex_ld=ex_mc=0, ex_rd=0, both counters 0; overrides all inputs.
REQ-034 During and after reset with idle inputs all control outputs are 0; reset mid-MCWAIT returns to RUN, no residual stall.

Verification
REQ-035 Load x5 issued, next ID reads rs1=x5 -> one cycle pc_stall=ifid_stall=idex_bubble=1, then normal; o_ldstall_cnt=1.
REQ-036 Load to x0, next reads x0 -> no stall; load x5 followed by rs2en=0 read of rs2id=x5 -> no stall.
REQ-037 Div issues, i_exu_mc_done after 4 cycles -> 3 cycles idex_hold=exmem_bubble=1, o_state=1; o_mcstall_cnt=3; then RUN.
REQ-038 Load-use hit same cycle as i_exu_redirect -> ifid_flush=idex_bubble=1, pc_stall=0, o_ldstall_cnt unchanged.
REQ-039 i_lsu_wait=1 for 2 cycles during load-use hit -> freeze outputs only, counter unchanged; bubble occurs after release.
REQ-040 Assert i_rst in MCWAIT -> next cycle o_state=0, counters 0, all stalls 0.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctl
// Brief    : Hazard controller for a 5-stage pipe: freeze, redirect flush,
//            multi-cycle EX wait and load-use interlock with stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctl #(
    parameter int REG_ADDRW = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_idu_valid,
    input  logic [REG_ADDRW-1:0] i_idu_rs1id,
    input  logic [REG_ADDRW-1:0] i_idu_rs2id,
    input  logic                 i_idu_rs1en,
    input  logic                 i_idu_rs2en,
    input  logic [REG_ADDRW-1:0] i_idu_rdid,
    input  logic                 i_idu_lden,
    input  logic                 i_idu_mcop,
    input  logic                 i_exu_mc_done,
    input  logic                 i_exu_redirect,
    input  logic                 i_lsu_wait,
    output logic                 o_pc_stall,
    output logic                 o_ifid_stall,
    output logic                 o_ifid_flush,
    output logic                 o_idex_bubble,
    output logic                 o_idex_hold,
    output logic                 o_exmem_bubble,
    output logic                 o_exmem_stall,
    output logic                 o_state,
    output logic [CNT_W-1:0]     o_ldstall_cnt,
    output logic [CNT_W-1:0]     o_mcstall_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MCWAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   ex_vld_q, ex_vld_d;
    logic [REG_ADDRW-1:0]   ex_rd_q, ex_rd_d;
    logic                   ex_ld_q, ex_ld_d;
    logic                   ex_mc_q, ex_mc_d;
    logic [CNT_W-1:0]       ldcnt_q, ldcnt_d;
    logic [CNT_W-1:0]       mccnt_q, mccnt_d;

    logic                   w_hit;
    logic                   w_mc_busy;

    // x0 is hardwired, so a load targeting it can never create a dependency.
    assign w_hit = i_idu_valid & ex_vld_q & ex_ld_q & (ex_rd_q != '0) &
                   ((i_idu_rs1en & (i_idu_rs1id == ex_rd_q)) |
                    (i_idu_rs2en & (i_idu_rs2id == ex_rd_q)));

    // MCWAIT always coincides with the multi-cycle op sitting in EX.
    assign w_mc_busy = (state_q == ST_MCWAIT) & ex_vld_q & ex_mc_q & ~i_exu_mc_done;

    always_comb begin
        o_pc_stall     = 1'b0;
        o_ifid_stall   = 1'b0;
        o_ifid_flush   = 1'b0;
        o_idex_bubble  = 1'b0;
        o_idex_hold    = 1'b0;
        o_exmem_bubble = 1'b0;
        o_exmem_stall  = 1'b0;
        state_d        = state_q;
        ex_vld_d       = ex_vld_q;
        ex_rd_d        = ex_rd_q;
        ex_ld_d        = ex_ld_q;
        ex_mc_d        = ex_mc_q;
        ldcnt_d        = ldcnt_q;
        mccnt_d        = mccnt_q;

        if (i_rst) begin
            // Control outputs stay quiet while reset is applied.
        end else if (i_lsu_wait) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_hold   = 1'b1;
            o_exmem_stall = 1'b1;
        end else if (i_exu_redirect) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            state_d       = ST_RUN;
            ex_vld_d      = 1'b0;
            ex_ld_d       = 1'b0;
            ex_mc_d       = 1'b0;
        end else if (w_mc_busy) begin
            o_pc_stall     = 1'b1;
            o_ifid_stall   = 1'b1;
            o_idex_hold    = 1'b1;
            o_exmem_bubble = 1'b1;
            mccnt_d        = mccnt_q + CNT_W'(1);
        end else if (w_hit) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_bubble = 1'b1;
            state_d       = ST_RUN;
            ex_vld_d      = 1'b0;
            ex_ld_d       = 1'b0;
            ex_mc_d       = 1'b0;
            ldcnt_d       = ldcnt_q + CNT_W'(1);
        end else begin
            ex_vld_d = i_idu_valid;
            ex_rd_d  = i_idu_rdid;
            ex_ld_d  = i_idu_lden;
            ex_mc_d  = i_idu_mcop;
            state_d  = (i_idu_valid & i_idu_mcop) ? ST_MCWAIT : ST_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_RUN;
            ex_vld_q <= 1'b0;
            ex_rd_q  <= '0;
            ex_ld_q  <= 1'b0;
            ex_mc_q  <= 1'b0;
            ldcnt_q  <= '0;
            mccnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            ex_vld_q <= ex_vld_d;
            ex_rd_q  <= ex_rd_d;
            ex_ld_q  <= ex_ld_d;
            ex_mc_q  <= ex_mc_d;
            ldcnt_q  <= ldcnt_d;
            mccnt_q  <= mccnt_d;
        end
    end

    assign o_state       = state_q;
    assign o_ldstall_cnt = ldcnt_q;
    assign o_mcstall_cnt = mccnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctl
// Brief    : Directed and random bench for pipe_hazard_ctl against a
//            pipeline-occupancy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctl;
    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          i_rst, i_idu_valid, i_idu_rs1en, i_idu_rs2en;
    logic [AW-1:0] i_idu_rs1id, i_idu_rs2id, i_idu_rdid;
    logic          i_idu_lden, i_idu_mcop, i_exu_mc_done, i_exu_redirect, i_lsu_wait;
    logic          o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble;
    logic          o_idex_hold, o_exmem_bubble, o_exmem_stall, o_state;
    logic [CW-1:0] o_ldstall_cnt, o_mcstall_cnt;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.REG_ADDRW(AW), .CNT_W(CW)) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_idu_valid(i_idu_valid),
        .i_idu_rs1id(i_idu_rs1id), .i_idu_rs2id(i_idu_rs2id),
        .i_idu_rs1en(i_idu_rs1en), .i_idu_rs2en(i_idu_rs2en),
        .i_idu_rdid(i_idu_rdid), .i_idu_lden(i_idu_lden), .i_idu_mcop(i_idu_mcop),
        .i_exu_mc_done(i_exu_mc_done), .i_exu_redirect(i_exu_redirect),
        .i_lsu_wait(i_lsu_wait), .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall),
        .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble),
        .o_idex_hold(o_idex_hold), .o_exmem_bubble(o_exmem_bubble),
        .o_exmem_stall(o_exmem_stall), .o_state(o_state),
        .o_ldstall_cnt(o_ldstall_cnt), .o_mcstall_cnt(o_mcstall_cnt)
    );

    // Model: what occupies EX, whether it is an unfinished multi-cycle op,
    // and how many stall cycles of each kind have been spent.
    logic          m_v, m_ld, m_busy;
    logic [AW-1:0] m_rd;
    logic [CW-1:0] m_ldc, m_mcc;

    function automatic logic model_hit();
        return i_idu_valid && m_v && m_ld && (m_rd != 0) &&
               ((i_idu_rs1en && i_idu_rs1id == m_rd) || (i_idu_rs2en && i_idu_rs2id == m_rd));
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold, exmem_bubble, exmem_stall}
    function automatic logic [6:0] model_ctl();
        if (i_rst)                      return 7'b0000000;
        if (i_lsu_wait)                 return 7'b1100101;
        if (i_exu_redirect)             return 7'b0011000;
        if (m_busy && !i_exu_mc_done)   return 7'b1100110;
        if (model_hit())                return 7'b1101000;
        return 7'b0000000;
    endfunction

    always @(posedge clk) begin
        if (i_rst) begin
            m_v = 0; m_ld = 0; m_busy = 0; m_rd = 0; m_ldc = 0; m_mcc = 0;
        end else if (i_lsu_wait) begin
            m_v = m_v;
        end else if (i_exu_redirect) begin
            m_v = 0; m_ld = 0; m_busy = 0;
        end else if (m_busy && !i_exu_mc_done) begin
            m_mcc = m_mcc + 1;
        end else if (model_hit()) begin
            m_ldc = m_ldc + 1;
            m_v = 0; m_ld = 0; m_busy = 0;
        end else begin
            m_v = i_idu_valid; m_rd = i_idu_rdid; m_ld = i_idu_lden;
            m_busy = i_idu_valid && i_idu_mcop;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ctl", {57'd0, o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble,
                          o_idex_hold, o_exmem_bubble, o_exmem_stall}, {57'd0, model_ctl()});
            check("state", {63'd0, o_state}, {63'd0, m_busy});
            check("ldcnt", {32'd0, o_ldstall_cnt}, {32'd0, m_ldc});
            check("mccnt", {32'd0, o_mcstall_cnt}, {32'd0, m_mcc});
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic idle();
        i_idu_valid = 0; i_idu_rs1id = 0; i_idu_rs2id = 0; i_idu_rs1en = 0; i_idu_rs2en = 0;
        i_idu_rdid = 0; i_idu_lden = 0; i_idu_mcop = 0;
        i_exu_mc_done = 0; i_exu_redirect = 0; i_lsu_wait = 0;
    endtask

    task automatic set_id(input logic v, input int r1, input logic e1, input int r2,
                          input logic e2, input int rd, input logic ld, input logic mc);
        i_idu_valid = v; i_idu_rs1id = AW'(r1); i_idu_rs1en = e1;
        i_idu_rs2id = AW'(r2); i_idu_rs2en = e2;
        i_idu_rdid = AW'(rd); i_idu_lden = ld; i_idu_mcop = mc;
    endtask

    task automatic do_reset();
        idle(); i_rst = 1; nxt(); i_rst = 0;
    endtask

    initial begin
        idle();
        i_rst = 1;
        nxt();
        chk_en = 1;
        mid();
        check("rst_pc", {63'd0, o_pc_stall}, 64'd0);
        check("rst_hold", {63'd0, o_idex_hold}, 64'd0);
        check("rst_state", {63'd0, o_state}, 64'd0);
        check("rst_ldcnt", {32'd0, o_ldstall_cnt}, 64'd0);
        nxt();
        i_rst = 0;

        // load x5 then dependent read of x5
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 0); mid(); check("lu_issue_pc", {63'd0, o_pc_stall}, 64'd0); nxt();
        set_id(1, 5, 1, 0, 0, 6, 0, 0); mid();
        check("lu_pc", {63'd0, o_pc_stall}, 64'd1);
        check("lu_ifid", {63'd0, o_ifid_stall}, 64'd1);
        check("lu_bub", {63'd0, o_idex_bubble}, 64'd1);
        check("lu_hold", {63'd0, o_idex_hold}, 64'd0);
        nxt(); mid();
        check("lu_after_pc", {63'd0, o_pc_stall}, 64'd0);
        check("lu_after_bub", {63'd0, o_idex_bubble}, 64'd0);
        check("lu_cnt", {32'd0, o_ldstall_cnt}, 64'd1);
        nxt();

        // x0 load and disabled rs2 read never hazard
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 0); nxt();
        set_id(1, 0, 1, 0, 0, 3, 0, 0); mid(); check("x0_pc", {63'd0, o_pc_stall}, 64'd0); nxt();
        set_id(1, 0, 0, 0, 0, 5, 1, 0); nxt();
        set_id(1, 3, 1, 5, 0, 4, 0, 0); mid();
        check("rs2dis_pc", {63'd0, o_pc_stall}, 64'd0);
        check("rs2dis_bub", {63'd0, o_idex_bubble}, 64'd0);
        check("rs2dis_cnt", {32'd0, o_ldstall_cnt}, 64'd0);
        nxt();

        // divide with done arriving on the fourth cycle in EX
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 0, 1); mid(); check("div_issue_hold", {63'd0, o_idex_hold}, 64'd0); nxt();
        set_id(1, 1, 1, 2, 1, 8, 0, 0);
        for (int k = 0; k < 3; k++) begin
            mid();
            check("div_hold", {63'd0, o_idex_hold}, 64'd1);
            check("div_exbub", {63'd0, o_exmem_bubble}, 64'd1);
            check("div_state", {63'd0, o_state}, 64'd1);
            nxt();
        end
        i_exu_mc_done = 1; mid();
        check("div_done_hold", {63'd0, o_idex_hold}, 64'd0);
        check("div_done_cnt", {32'd0, o_mcstall_cnt}, 64'd3);
        nxt();
        i_exu_mc_done = 0; mid();
        check("div_run_state", {63'd0, o_state}, 64'd0);
        check("div_run_pc", {63'd0, o_pc_stall}, 64'd0);
        nxt();

        // redirect beats a load-use hit
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 0); nxt();
        set_id(1, 5, 1, 0, 0, 6, 0, 0); i_exu_redirect = 1; mid();
        check("rdr_flush", {63'd0, o_ifid_flush}, 64'd1);
        check("rdr_bub", {63'd0, o_idex_bubble}, 64'd1);
        check("rdr_pc", {63'd0, o_pc_stall}, 64'd0);
        nxt();
        idle(); mid(); check("rdr_cnt", {32'd0, o_ldstall_cnt}, 64'd0); nxt();

        // memory wait freezes a pending load-use hit
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 0); nxt();
        set_id(1, 0, 0, 5, 1, 6, 0, 0); i_lsu_wait = 1;
        for (int k = 0; k < 2; k++) begin
            mid();
            check("frz_pc", {63'd0, o_pc_stall}, 64'd1);
            check("frz_exstall", {63'd0, o_exmem_stall}, 64'd1);
            check("frz_bub", {63'd0, o_idex_bubble}, 64'd0);
            check("frz_cnt", {32'd0, o_ldstall_cnt}, 64'd0);
            nxt();
        end
        i_lsu_wait = 0; mid();
        check("rel_bub", {63'd0, o_idex_bubble}, 64'd1);
        check("rel_hold", {63'd0, o_idex_hold}, 64'd0);
        nxt(); mid();
        check("rel_cnt", {32'd0, o_ldstall_cnt}, 64'd1);
        nxt();

        // reset in the middle of a multi-cycle wait
        do_reset();
        set_id(1, 0, 0, 0, 0, 9, 0, 1); nxt();
        idle();
        for (int k = 0; k < 2; k++) begin
            mid(); check("mcw_state", {63'd0, o_state}, 64'd1); nxt();
        end
        i_rst = 1; mid(); check("mcw_rst_hold", {63'd0, o_idex_hold}, 64'd0); nxt();
        i_rst = 0; mid();
        check("post_rst_state", {63'd0, o_state}, 64'd0);
        check("post_rst_mccnt", {32'd0, o_mcstall_cnt}, 64'd0);
        check("post_rst_hold", {63'd0, o_idex_hold}, 64'd0);
        check("post_rst_pc", {63'd0, o_pc_stall}, 64'd0);
        nxt();

        // random traffic, small register range to provoke dependencies
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            i_rst          = ($urandom_range(0, 199) == 0);
            i_idu_valid    = ($urandom_range(0, 9) < 8);
            i_idu_rs1id    = AW'($urandom_range(0, 3));
            i_idu_rs2id    = AW'($urandom_range(0, 3));
            i_idu_rs1en    = $urandom_range(0, 1) == 1;
            i_idu_rs2en    = $urandom_range(0, 1) == 1;
            i_idu_rdid     = AW'($urandom_range(0, 3));
            i_idu_lden     = ($urandom_range(0, 9) < 3);
            i_idu_mcop     = ($urandom_range(0, 9) < 1);
            i_exu_mc_done  = ($urandom_range(0, 9) < 3);
            i_exu_redirect = ($urandom_range(0, 19) == 0);
            i_lsu_wait     = ($urandom_range(0, 9) == 0);
            nxt();
        end
        idle(); i_rst = 0;
        mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
